// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the USB data FIFO write arbiter.
// Requester indices match the bit positions of the req_* vectors.
package usb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam logic [15:0] ABORT_WORD     = 16'hFFEE;
  localparam int          DATA_WIDTH_DEF = 16;

  localparam int REQ_SCURVE = 0;
  localparam int REQ_ACQ    = 1;
  localparam int REQ_SWEEP  = 2;

endpackage

// File: rtl/usb_fifo_write_arbiter_if.sv
// Producer lanes, USB data FIFO write port and arbiter status.
// The arbiter uses the master modport; the producer/FIFO side uses slave.
interface usb_fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          usb_data_fifo_full;
  logic                          usb_data_fifo_wr_en;
  logic [DATA_WIDTH-1:0]         usb_data_fifo_wr_din;
  logic [NUM_REQ-1:0]            Grant_Chn;
  logic                          Arb_Busy;

  modport master (
    input  req_valid, req_data, req_last, usb_data_fifo_full,
    output req_ready, usb_data_fifo_wr_en, usb_data_fifo_wr_din, Grant_Chn, Arb_Busy
  );

  modport slave (
    output req_valid, req_data, req_last, usb_data_fifo_full,
    input  req_ready, usb_data_fifo_wr_en, usb_data_fifo_wr_din, Grant_Chn, Arb_Busy
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: rotate the request vector so the search starts just
// after the last winner, take the lowest set bit, rotate the one-hot back.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_req
);

  int                 sh;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;

  always_comb begin
    sh = (int'(last_grant) + 1) % NUM_REQ;
    rot = '0;
    for (int j = 0; j < NUM_REQ; j++) rot[j] = req[(j + sh) % NUM_REQ];
    rot_oh = rot & (~rot + 1'b1);
    pick = '0;
    for (int k = 0; k < NUM_REQ; k++) pick[k] = rot_oh[(k + NUM_REQ - sh) % NUM_REQ];
  end

  assign any_req = |req;

endmodule

// File: rtl/usb_fifo_write_arbiter.sv
// Packet-level round-robin arbiter in front of the USB data FIFO write port.
// A grant is held for a whole packet; a packet stalled too long is closed with ABORT_WORD.
module usb_fifo_write_arbiter
  import usb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                      Clk,
  input logic                      reset,
  usb_fifo_write_arbiter_if.master bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e            state;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    pick;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         g_idx;
  logic [IW-1:0]         pick_idx;
  logic [CW-1:0]         stall_cnt;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_din;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  any_req;
  logic                  g_valid;
  logic                  g_last;
  logic                  full;
  logic                  beat;
  logic                  timed_out;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = IW'(i);
  end

  assign full      = bus.usb_data_fifo_full;
  assign g_valid   = |(bus.req_valid & grant);
  assign g_last    = |(bus.req_last & grant);
  assign g_data    = bus.req_data[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign beat      = g_valid & ~full;
  assign timed_out = (stall_cnt == CW'(TIMEOUT_CYCLES));

  // Full gates ready combinationally; the FIFO's depth-2 threshold covers the registered write.
  assign bus.req_ready            = grant & bus.req_valid & {NUM_REQ{~full}};
  assign bus.usb_data_fifo_wr_en  = wr_en;
  assign bus.usb_data_fifo_wr_din = wr_din;
  assign bus.Grant_Chn            = grant;
  assign bus.Arb_Busy             = (state == XFER);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      g_idx      <= '0;
      stall_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_din     <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            g_idx <= pick_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            wr_en     <= 1'b1;
            wr_din    <= g_data;
            stall_cnt <= '0;
            if (g_last) begin
              last_grant <= g_idx;
              grant      <= '0;
              state      <= IDLE;
            end
          end else if (timed_out && !full) begin
            wr_en      <= 1'b1;
            wr_din     <= DATA_WIDTH'(ABORT_WORD);
            stall_cnt  <= '0;
            last_grant <= g_idx;
            grant      <= '0;
            state      <= IDLE;
          end else if (!g_valid && !timed_out) begin
            // Cycles held off only by full neither count nor clear.
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fifo_write_arbiter.sv
// Self-checking bench: a behavioural model (owner index, last winner, stall count)
// is compared with the DUT every cycle; directed scenarios add literal expectations.
module tb_usb_fifo_write_arbiter;
  import usb_arb_pkg::*;

  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int TMO = 1024;

  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  usb_fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  usb_fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk   (Clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: owner = granted requester or -1, last = previous winner, stalls = stalled cycles.
  int            m_owner;
  int            m_last;
  int            m_stalls;
  logic          m_wr_en;
  logic [DW-1:0] m_din;

  logic [DW:0]   pq [N][$];
  logic [N-1:0]  rdy_seen;
  int            idle_pct;
  logic [DW-1:0] wlog[$];
  int            wcyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 16'hDEAD;
  endfunction

  function automatic int wc(input int i);
    return (i < wcyc.size()) ? wcyc[i] : -100000;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_stalls = 0;
    m_wr_en  = 1'b0;
    m_din    = '0;
  endtask

  task automatic model_step();
    logic found;
    logic full;
    full    = bus.usb_data_fifo_full;
    m_wr_en = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && bus.req_valid[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          found   = 1'b1;
        end
      end
    end else if (bus.req_valid[m_owner] && !full) begin
      m_wr_en  = 1'b1;
      m_din    = bus.req_data[m_owner*DW +: DW];
      m_stalls = 0;
      if (bus.req_last[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (m_stalls >= TMO && !full) begin
      m_wr_en  = 1'b1;
      m_din    = ABORT_WORD;
      m_stalls = 0;
      m_last   = m_owner;
      m_owner  = -1;
    end else if (!bus.req_valid[m_owner] && m_stalls < TMO) begin
      m_stalls++;
    end
  endtask

  // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    @(negedge Clk);
    cyc++;
    if (rst) model_reset();
    eg = '0;
    er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (bus.req_valid[m_owner] && !bus.usb_data_fifo_full) er[m_owner] = 1'b1;
    end
    check("grant",  32'(bus.Grant_Chn), 32'(eg));
    check("busy",   32'(bus.Arb_Busy), 32'(m_owner >= 0));
    check("ready",  32'(bus.req_ready), 32'(er));
    check("wr_en",  32'(bus.usb_data_fifo_wr_en), 32'(m_wr_en));
    check("wr_din", 32'(bus.usb_data_fifo_wr_din), 32'(m_din));
    if (bus.usb_data_fifo_wr_en === 1'b1) begin
      wlog.push_back(bus.usb_data_fifo_wr_din);
      wcyc.push_back(cyc);
    end
    rdy_seen = bus.req_ready;
    if (!rst) model_step();
    @(posedge Clk);
    #1;
  endtask

  // Producers: pop an accepted word, hold an unaccepted one, otherwise maybe present the next.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && rdy_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (!(bus.req_valid[i] && !rdy_seen[i] && pq[i].size() > 0)) begin
        if (pq[i].size() > 0 && $urandom_range(99) >= idle_pct) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_last[i]          = pq[i][0][DW];
          bus.req_data[i*DW +: DW] = pq[i][0][DW-1:0];
        end else begin
          bus.req_valid[i]         = 1'b0;
          bus.req_last[i]          = 1'($urandom_range(1));
          bus.req_data[i*DW +: DW] = DW'($urandom);
        end
      end
    end
  endtask

  task automatic push(input int r, input logic lst, input logic [DW-1:0] d);
    pq[r].push_back({lst, d});
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      drive();
      bus.usb_data_fifo_full = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_random(input int cycles, input int ipct, input int full_pct);
    int len;
    logic lst;
    idle_pct = ipct;
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() < 2 && $urandom_range(3) == 0) begin
          len = $urandom_range(6, 1);
          for (int w = 0; w < len; w++) begin
            lst = (w == len - 1);
            push(i, lst, DW'($urandom));
          end
        end
      end
      drive();
      bus.usb_data_fifo_full = ($urandom_range(99) < full_pct);
      tick();
    end
  endtask

  initial begin
    int c0;
    int fall_cyc;
    int rdy_cnt;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.usb_data_fifo_full = 1'b0;
    rdy_seen = '0;
    idle_pct = 0;
    model_reset();

    // Reset state
    tick();
    check("rst_grant",  32'(bus.Grant_Chn), 32'h0);
    check("rst_wr_en",  32'(bus.usb_data_fifo_wr_en), 32'h0);
    check("rst_wr_din", 32'(bus.usb_data_fifo_wr_din), 32'h0);
    check("rst_busy",   32'(bus.Arb_Busy), 32'h0);
    check("rst_ready",  32'(bus.req_ready), 32'h0);
    rst = 1'b0;

    // Single packet from SCurve
    wlog.delete(); wcyc.delete();
    push(REQ_SCURVE, 1'b0, 16'h5343);
    push(REQ_SCURVE, 1'b0, 16'h4305);
    push(REQ_SCURVE, 1'b1, 16'hFF45);
    run(1);
    c0 = cyc;
    check("t1_grant", 32'(bus.Grant_Chn), 32'b001);
    check("t1_busy",  32'(bus.Arb_Busy), 32'h1);
    run(7);
    check("t1_nwr", 32'(wlog.size()), 32'd3);
    check("t1_w0",  32'(wl(0)), 32'h5343);
    check("t1_w1",  32'(wl(1)), 32'h4305);
    check("t1_w2",  32'(wl(2)), 32'hFF45);
    check("t1_lat", 32'(wc(0) - c0), 32'd2);
    check("t1_seq", 32'(wc(2) - wc(0)), 32'd2);
    check("t1_idle_grant", 32'(bus.Grant_Chn), 32'h0);

    // Round robin: SCurve and ACQ both pending after reset
    pulse_reset();
    wlog.delete(); wcyc.delete();
    push(REQ_SCURVE, 1'b0, 16'hA000); push(REQ_SCURVE, 1'b1, 16'hA001);
    push(REQ_SCURVE, 1'b0, 16'hA002); push(REQ_SCURVE, 1'b1, 16'hA003);
    push(REQ_ACQ,    1'b0, 16'hB000); push(REQ_ACQ,    1'b1, 16'hB001);
    run(14);
    check("t2_nwr", 32'(wlog.size()), 32'd6);
    check("t2_w0", 32'(wl(0)), 32'hA000);
    check("t2_w1", 32'(wl(1)), 32'hA001);
    check("t2_w2", 32'(wl(2)), 32'hB000);
    check("t2_w3", 32'(wl(3)), 32'hB001);
    check("t2_w4", 32'(wl(4)), 32'hA002);
    check("t2_w5", 32'(wl(5)), 32'hA003);
    check("t2_gap1", 32'(wc(2) - wc(1)), 32'd2);
    check("t2_gap2", 32'(wc(4) - wc(3)), 32'd2);

    // Backpressure: full for 5 cycles after the 2nd of 4 words
    wlog.delete(); wcyc.delete();
    for (int w = 0; w < 4; w++) push(REQ_ACQ, (w == 3), DW'(16'hC000 + w));
    rdy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      drive();
      bus.usb_data_fifo_full = (k >= 3 && k <= 7);
      tick();
      if (rdy_seen[REQ_ACQ]) rdy_cnt++;
    end
    check("t3_nwr", 32'(wlog.size()), 32'd4);
    for (int w = 0; w < 4; w++) check("t3_data", 32'(wl(w)), 32'(16'hC000 + w));
    check("t3_hold", 32'(wc(2) - wc(1)), 32'd6);
    check("t3_nready", 32'(rdy_cnt), 32'd4);

    // Timeout: sweep sends one word then stops; SCurve pending.
    // 1024 stalled cycles are counted, the next cycle issues the abort.
    wlog.delete(); wcyc.delete();
    push(REQ_SWEEP, 1'b0, 16'h2222);
    push(REQ_SCURVE, 1'b1, 16'h0001);
    run(1);
    check("t4_grant", 32'(bus.Grant_Chn), 32'b100);
    run(1040);
    check("t4_nwr", 32'(wlog.size()), 32'd3);
    check("t4_w0", 32'(wl(0)), 32'h2222);
    check("t4_abort", 32'(wl(1)), 32'hFFEE);
    check("t4_w2", 32'(wl(2)), 32'h0001);
    check("t4_tmo", 32'(wc(1) - wc(0)), 32'd1025);
    check("t4_next", 32'(wc(2) - wc(1)), 32'd2);

    // Abort held off by full
    wlog.delete(); wcyc.delete();
    push(REQ_ACQ, 1'b0, 16'h1111);
    fall_cyc = 0;
    for (int k = 0; k < 1060; k++) begin
      drive();
      bus.usb_data_fifo_full = (k >= 1020 && k < 1040);
      tick();
      if (k == 1040) fall_cyc = cyc;
    end
    check("t5_nwr", 32'(wlog.size()), 32'd2);
    check("t5_abort", 32'(wl(1)), 32'hFFEE);
    check("t5_when", 32'(wc(1) - fall_cyc), 32'd1);
    check("t5_span", 32'(wc(1) - wc(0)), 32'd1039);

    // Reset after 2 of 5 words
    for (int w = 0; w < 5; w++) push(REQ_SWEEP, (w == 4), DW'(16'hD000 + w));
    run(3);
    check("t6_pre_busy", 32'(bus.Arb_Busy), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_grant",  32'(bus.Grant_Chn), 32'h0);
    check("t6_wr_en",  32'(bus.usb_data_fifo_wr_en), 32'h0);
    check("t6_wr_din", 32'(bus.usb_data_fifo_wr_din), 32'h0);
    check("t6_busy",   32'(bus.Arb_Busy), 32'h0);
    check("t6_ready",  32'(bus.req_ready), 32'h0);
    for (int i = 0; i < N; i++) pq[i].delete();
    bus.req_valid = '0;
    bus.req_last  = '0;
    tick();
    tick();
    rst = 1'b0;
    wlog.delete(); wcyc.delete();
    push(REQ_SCURVE, 1'b0, 16'h0A0A); push(REQ_SCURVE, 1'b1, 16'h0B0B);
    push(REQ_SWEEP,  1'b1, 16'h2020);
    run(1);
    check("t6_first", 32'(bus.Grant_Chn), 32'b001);
    run(10);
    check("t6_nwr", 32'(wlog.size()), 32'd3);
    check("t6_w0", 32'(wl(0)), 32'h0A0A);
    check("t6_w1", 32'(wl(1)), 32'h0B0B);
    check("t6_w2", 32'(wl(2)), 32'h2020);

    // Randomized traffic against the model
    run_random(3000, 25, 20);
    run_random(2000, 60, 40);
    run_random(1000, 0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb_fifo_write_arbiter.md
# usb_fifo_write_arbiter

Packet-level round-robin arbiter that shares the single USB data FIFO write port between the DAQ's data producers: SCurve test controller, ACQ readout and sweep test. Each requester streams 16-bit words with a last-word flag. The arbiter grants one requester at a time and holds the grant for a whole packet, so packet headers, bodies and trailers from different producers are never interleaved in the USB stream. It sits between the producers and the USB data FIFO, in place of each producer driving the FIFO directly.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; index 0 = SCurve, 1 = ACQ readout, 2 = sweep test
- DATA_WIDTH, 16, word width
- TIMEOUT_CYCLES, 1024, number of consecutive stalled cycles inside a packet before the packet is aborted

Ports:
- Clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a word on its data lane
- req_data  in  NUM_REQ*DATA_WIDTH  word of requester i, on bits [i*16 +: 16]
- req_last  in  NUM_REQ  current word is the last word of the packet
- req_ready  out  NUM_REQ  word accepted this cycle (combinational)
- usb_data_fifo_full  in  1  FIFO programmable-full; the FIFO threshold is set to depth−2
- usb_data_fifo_wr_en  out  1  registered write strobe
- usb_data_fifo_wr_din  out  DATA_WIDTH  registered write data
- Grant_Chn  out  NUM_REQ  registered one-hot grant; all zeros when no requester is granted
- Arb_Busy  out  1  high while in XFER

## Operation
- States: IDLE, XFER.
- **IDLE:**
  - If any req_valid is high, select the first valid index at or after Last_Grant+1, wrapping modulo NUM_REQ.
  - Load that index into Grant_Chn and go to XFER.
  - Otherwise stay in IDLE with Grant_Chn = 0.
- **XFER, ready:** req_ready[g] = req_valid[g] & ~usb_data_fifo_full. All other ready bits are 0.
- **XFER, accepted word (beat):** on every beat, wr_din <= req_data[g], wr_en <= 1 and the stall counter clears. With no beat, wr_en <= 0.
- **XFER, end of packet:** a beat with req_last high does all of the following:
  - sets Last_Grant <= g;
  - clears Grant_Chn;
  - returns to IDLE.
- **Stall counter:**
  - Counts XFER cycles in which req_valid[g] is low.
  - Cycles held off only by full do not count, and do not clear the counter.
- **Timeout:**
  - When the counter reaches TIMEOUT_CYCLES and full is low, write ABORT_WORD 16'hFFEE, set Last_Grant <= g, clear the grant and go to IDLE.
  - If full is high at that moment, wait until it is low, then do the same.
  - The abandoned requester's remaining words are treated as a new packet when it next wins.
- **Reset values:**
  - req_ready = 0, wr_en = 0, wr_din = 0, Grant_Chn = 0, Arb_Busy = 0;
  - state = IDLE, stall counter = 0;
  - Last_Grant = NUM_REQ−1, so requester 0 wins first after reset.
- **Reset mid-packet:** the packet is dropped with no trailer. Resynchronising the stream is the host's job, via the packet headers.

## Timing
- Grant latency: req_valid sampled in IDLE at cycle t gives Grant_Chn at t+1. The first beat can be accepted in cycle t+1.
- Write latency: a beat at cycle t gives wr_en and wr_din at t+1.
- Throughput: one word per cycle inside a packet.
- Inter-packet gap: minimum one IDLE cycle between a last beat and the next grant, even when the same requester is still valid.
- Full handling:
  - full is combinational into ready, so no beat is accepted while full is high.
  - The depth−2 threshold absorbs the one in-flight registered write plus FIFO full latency.
- A requester's valid rising while another requester holds the grant has no effect until the arbiter returns to IDLE.
- req_last with req_valid low is ignored.
- Requesters must hold data, valid and last stable until ready.

## Structure
- Package usb_arb_pkg holds:
  - the state enum {IDLE, XFER};
  - ABORT_WORD = 16'hFFEE;
  - DATA_WIDTH_DEF = 16;
  - the requester index constants REQ_SCURVE = 0, REQ_ACQ = 1, REQ_SWEEP = 2.
- One sub-module: rr_pick.
  - Combinational rotate, priority-encode, rotate back.
  - Inputs: req vector, Last_Grant. Outputs: one-hot pick and any_req.
- Top level holds the FSM, the stall counter and the output registers.

## Test plan
- Single packet: requester 0 sends 0x5343, 0x4305, 0xFF45 (last on the third word) with full low → Grant_Chn = 3'b001 one cycle after valid; wr_en high for 3 consecutive cycles with that data; back to IDLE.
- Round-robin: after reset, requesters 0 and 1 both assert 2-word packets and keep them pending → FIFO order is packet 0, packet 1, packet 0, with no interleaving and a 1-cycle gap between packets.
- Backpressure: full rises after the 2nd of 4 words and is held for 5 cycles → ready and wr_en stay low for those 5 cycles; words 3 and 4 follow with no loss or duplication.
- Timeout: requester 2 sends 1 word without last, then drops valid → exactly 1024 stalled cycles later 0xFFEE is written and the grant clears; a pending requester 0 is granted next.
- Abort under full: full is held high when the timeout is reached → 0xFFEE is written only in the cycle after full falls.
- Reset mid-packet: reset pulses after 2 of 5 words → all outputs go to 0 immediately; after reset, requester 0 is granted first and its new packet writes cleanly.
